// File: rtl/ap_mem_reader.sv
// Read-side sequencer for the vector-row memory: walks read_address over a
// requested row range and streams each row downstream with valid/ready.
module ap_mem_reader #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int memory_height = 1000,
  parameter int address_width = $clog2(memory_height) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic [address_width-1:0]             length,
  output logic [address_width-1:0]             read_address,
  input  logic [element_width*no_of_units-1:0] memory_output,
  output logic [element_width*no_of_units-1:0] out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_RUN   | fetching rows, one per accepted output slot
  // S_DRAIN | final row fetched, waiting for the consumer to take it
  // S_DONE  | burst finished, pulse done next cycle and return to idle

  localparam int AW = address_width;
  localparam int RW = element_width * no_of_units;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [AW-1:0]   r_read_address;
  logic [AW-1:0]   r_remaining;
  logic [RW-1:0]   r_out_data;
  logic            r_out_valid;
  logic            r_out_last;
  logic            r_busy;
  logic            r_done;
  logic            w_fetch;
  logic            w_final;
  logic            w_consume;
  logic [AW-1:0]   w_next_address;

  // A row may be fetched whenever the output slot is empty or being emptied
  assign w_fetch        = !r_out_valid || out_ready;
  assign w_final        = (r_remaining == AW'(1));
  assign w_consume      = r_out_valid && out_ready;
  assign w_next_address = (r_read_address == AW'(memory_height)) ? '0
                                                                 : r_read_address + AW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = (length == '0) ? S_DONE : S_RUN;
      S_RUN:   if (w_fetch && w_final) w_next = S_DRAIN;
      S_DRAIN: if (w_consume) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_address <= '0;
      r_remaining    <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_out_last     <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && (length != '0)) begin
            r_read_address <= base_address;
            r_remaining    <= length;
            r_busy         <= 1'b1;
          end
        end
        S_RUN: begin
          // consume and refill on the same edge, so no bubble between rows
          if (w_fetch) begin
            r_out_data     <= memory_output;
            r_out_valid    <= 1'b1;
            r_out_last     <= w_final;
            r_remaining    <= r_remaining - AW'(1);
            r_read_address <= w_next_address;
          end
        end
        S_DRAIN: begin
          if (w_consume) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign read_address = r_read_address;
  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign out_last     = r_out_last;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_ap_mem_reader.sv
// Scoreboard bench for ap_mem_reader: expected rows are queued when a burst
// is issued and a negedge monitor pops and compares each accepted beat.
module tb_ap_mem_reader;

  localparam int EW = 32;
  localparam int NU = 8;
  localparam int MH = 1000;
  localparam int AW = $clog2(MH) + 1;
  localparam int RW = EW * NU;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_address;
  logic [AW-1:0] length;
  logic [AW-1:0] read_address;
  logic [RW-1:0] memory_output;
  logic [RW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  ap_mem_reader #(
    .element_width(EW), .no_of_units(NU), .memory_height(MH), .address_width(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .base_address(base_address), .length(length),
    .read_address(read_address), .memory_output(memory_output),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] row_of(input int k);
    logic [EW-1:0] e;
    e = EW'(k);
    return {NU{e}};
  endfunction

  // Row k holds the value k in every element
  assign memory_output = row_of(int'(read_address));

  typedef struct {
    logic [RW-1:0] data;
    logic          last;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_start  = 0;
  int   beats    = 0;
  bit   saw_valid;
  bit   saw_busy;
  bit   toggle_mode = 1'b0;
  int   tog_idx     = 0;
  logic [5:0] ready_pat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name,
                     input logic [RW-1:0] act, input logic [RW-1:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Consumer ready: held high, or cycling 1,0,0,1,0,1 when toggling
  always @(posedge clk) begin
    #1;
    if (toggle_mode) begin
      out_ready = ready_pat[tog_idx];
      tog_idx   = (tog_idx + 1) % 6;
    end else begin
      out_ready = 1'b1;
    end
  end

  // Monitor: compares every accepted beat and checks stall stability
  bit            have_prev = 1'b0;
  logic          p_valid, p_ready, p_last;
  logic [RW-1:0] p_data;
  logic [AW-1:0] p_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && p_valid && !p_ready) begin
        chk(out_valid == 1'b1, "stall_valid", RW'(out_valid), RW'(1));
        chk(out_data == p_data, "stall_data", out_data, p_data);
        chk(out_last == p_last, "stall_last", RW'(out_last), RW'(p_last));
        chk(read_address == p_addr, "stall_addr", RW'(read_address), RW'(p_addr));
      end
      if (out_valid) saw_valid = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (out_valid && out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", out_data, '0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(out_data == e.data, "row_data", out_data, e.data);
          chk(out_last == e.last, "row_last", RW'(out_last), RW'(e.last));
        end
      end
      have_prev = 1'b1;
      p_valid   = out_valid;
      p_ready   = out_ready;
      p_last    = out_last;
      p_data    = out_data;
      p_addr    = read_address;
    end
  end

  task automatic push_burst(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.data = row_of((base + i) % (MH + 1));
      e.last = (i == len - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_pulse(input int base, input int len);
    @(posedge clk);
    #1;
    start        = 1'b1;
    base_address = AW'(base);
    length       = AW'(len);
    n_start      = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int dt);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk(got, "done_seen", RW'(got), RW'(1));
    dt = cyc - n_start;
  endtask

  task automatic wait_first_valid(output int dt);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    chk(got, "first_valid_seen", RW'(got), RW'(1));
    dt = cyc - n_start;
  endtask

  task automatic check_idle_after_done();
    @(negedge clk);
    chk(done == 1'b0, "done_one_cycle", RW'(done), RW'(0));
    chk(busy == 1'b0, "busy_low_after", RW'(busy), RW'(0));
    chk(exp_q.size() == 0, "queue_drained", RW'(exp_q.size()), RW'(0));
  endtask

  initial begin
    int dt;
    int wrap_rows[5];
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dt;
    int wrap_rows[5];
    int b0;
    bit got;
    ready_pat    = 6'b101001;
    rst_n        = 1'b0;
    start        = 1'b0;
    base_address = '0;
    length       = '0;
    out_ready    = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk(read_address == '0, "rst_addr", RW'(read_address), RW'(0));
    chk(out_data == '0, "rst_data", out_data, '0);
    chk(out_valid == 1'b0, "rst_valid", RW'(out_valid), RW'(0));
    chk(busy == 1'b0 && done == 1'b0, "rst_busy_done", RW'({busy, done}), RW'(0));

    // Burst 5..8 with ready held high: timing and content
    push_burst(5, 4);
    start_pulse(5, 4);
    wait_first_valid(dt);
    chk(dt == 2, "first_valid_latency", RW'(dt), RW'(2));
    chk(busy == 1'b1, "busy_during", RW'(busy), RW'(1));
    wait_done(dt);
    chk(dt == 7, "done_latency", RW'(dt), RW'(7));
    check_idle_after_done();

    // Same burst with back-pressure
    tog_idx     = 0;
    toggle_mode = 1'b1;
    beats       = 0;
    push_burst(5, 4);
    start_pulse(5, 4);
    wait_done(dt);
    chk(beats == 4, "stall_beats", RW'(beats), RW'(4));
    check_idle_after_done();
    toggle_mode = 1'b0;

    // Address wrap at the top of memory
    wrap_rows = '{998, 999, 1000, 0, 1};
    for (int i = 0; i < 5; i++) begin
      exp_t e;
      e.data = row_of(wrap_rows[i]);
      e.last = (i == 4);
      exp_q.push_back(e);
    end
    start_pulse(998, 5);
    wait_done(dt);
    check_idle_after_done();

    // Zero-length request
    saw_valid = 1'b0;
    saw_busy  = 1'b0;
    start_pulse(7, 0);
    wait_done(dt);
    chk(dt == 2, "len0_done_latency", RW'(dt), RW'(2));
    check_idle_after_done();
    chk(saw_valid == 1'b0, "len0_no_valid", RW'(saw_valid), RW'(0));
    chk(saw_busy == 1'b0, "len0_no_busy", RW'(saw_busy), RW'(0));

    // Start during a burst is ignored
    tog_idx     = 0;
    toggle_mode = 1'b1;
    beats       = 0;
    push_burst(10, 6);
    start_pulse(10, 6);
    b0 = n_start;
    repeat (2) @(posedge clk);
    start_pulse(100, 3);
    n_start = b0;
    wait_done(dt);
    chk(beats == 6, "midstart_beats", RW'(beats), RW'(6));
    check_idle_after_done();
    toggle_mode = 1'b0;
    saw_valid   = 1'b0;
    saw_busy    = 1'b0;
    repeat (6) @(negedge clk);
    chk(saw_valid == 1'b0 && saw_busy == 1'b0, "midstart_no_second",
        RW'({saw_valid, saw_busy}), RW'(0));

    // Reset in the middle of a 6-row burst
    beats = 0;
    push_burst(40, 6);
    start_pulse(40, 6);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (beats >= 2) got = 1'b1;
    end
    chk(got, "two_beats_before_reset", RW'(beats), RW'(2));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk(out_valid == 1'b0 && out_last == 1'b0 && busy == 1'b0 && done == 1'b0,
        "async_rst_flags", RW'({out_valid, out_last, busy, done}), RW'(0));
    chk(out_data == '0, "async_rst_data", out_data, '0);
    chk(read_address == '0, "async_rst_addr", RW'(read_address), RW'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    beats = 0;
    push_burst(20, 2);
    start_pulse(20, 2);
    wait_done(dt);
    chk(dt == 5, "post_reset_done_latency", RW'(dt), RW'(5));
    chk(beats == 2, "post_reset_beats", RW'(beats), RW'(2));
    check_idle_after_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
